// File: rtl/mult_div_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Op encodings, FSM states and counter sizing.
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic op_signed(op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_div(op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Operand, control and HI/LO result bundle of the mult/div unit.
// master drives operands (EX stage), slave is the unit itself.
interface mult_div_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             start;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output a, b, op, start, mthi, mtlo,
        input  hi_out, lo_out, busy, done, divzero
    );

    modport slave (
        input  a, b, op, start, mthi, mtlo,
        output hi_out, lo_out, busy, done, divzero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per clock.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic       clock,
    input logic       reset,
    mult_div_if.slave bus
);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             neg_res;
    logic             neg_rem;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done_q;
    logic             dz_q;

    op_t              op_in;
    logic             sgn_in;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign op_in  = op_t'(bus.op);
    assign sgn_in = op_signed(op_in);
    assign a_abs  = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs  = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // acc:qr is the running product, or remainder:dividend/quotient
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rsh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign msum     = {1'b0, acc} + (qr[0] ? {1'b0, mcand} : '0);
    assign rsh      = {acc, qr[WIDTH-1]};
    assign diff     = {1'b0, rsh} - {2'b00, mcand};
    assign prod     = {acc, qr};
    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -qr : qr;
    assign rem_fix  = neg_rem ? -acc : acc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= OP_MULT;
            acc     <= '0;
            qr      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= op_in;
                        neg_res <= sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem <= sgn_in & bus.a[WIDTH-1];
                        cnt     <= '0;
                        if (op_div(op_in) && (bus.b == '0)) begin
                            dz    <= 1'b1;
                            acc   <= bus.a;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            acc   <= '0;
                            qr    <= op_div(op_in) ? a_abs : b_abs;
                            mcand <= op_div(op_in) ? b_abs : a_abs;
                            state <= CALC;
                        end
                    end else begin
                        if (bus.mthi) hi <= bus.a;
                        if (bus.mtlo) lo <= bus.a;
                    end
                end
                CALC: begin
                    if (op_div(op_q)) begin
                        if (!diff[WIDTH+1]) begin
                            acc <= diff[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= rsh[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= msum[WIDTH:1];
                        qr  <= {msum[0], qr[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        hi   <= acc;
                        lo   <= '1;
                        dz_q <= 1'b1;
                    end else if (op_div(op_q)) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi_out  = hi;
    assign bus.lo_out  = lo;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.divzero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors,
// expected HI/LO queued at issue, compared when done pulses.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 want done=0");
            end else begin
                e = sbq.pop_front();
                check({e.name, "_hi"}, bus.hi_out, e.hi);
                check({e.name, "_lo"}, bus.lo_out, e.lo);
                check({e.name, "_divzero"}, 32'(bus.divzero), 32'(e.dz));
            end
        end else if (bus.divzero === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_divzero: got divzero=1 want 0");
        end
    end

    task automatic wait_done(input string name, input int lat);
        int k;
        logic dropped;
        k = 0;
        dropped = 1'b0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) dropped = 1'b1;
        end
        check({name, "_latency"}, 32'(k), 32'(lat));
        check({name, "_busy_held"}, 32'(dropped), 32'd0);
        check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz,
                          input int lat, input string name);
        @(negedge clock);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sbq.push_back('{ehi, elo, edz, name});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check({name, "_busy_e0"}, 32'(bus.busy), 32'd1);
        wait_done(name, lat);
    endtask

    initial begin
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = 2'b00;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", bus.hi_out, 32'h0);
        check("rst_lo", bus.lo_out, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_divzero", 32'(bus.divzero), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op(2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mult_neg3x7");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 33, "multu_max");
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, "mult_m1xm1");
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33, "mult_minxmin");
        run_op(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, "div_neg7d2");
        run_op(2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 33, "div_7dneg2");
        run_op(2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 33, "divu_7d2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, "div_ovf");
        run_op(2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1, "divu_zero");
        run_op(2'b10, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1, "div_zero");

        // MTHI while idle, then moves and start issued while busy
        @(negedge clock);
        bus.a    = 32'hDEADBEEF;
        bus.mthi = 1'b1;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        check("mthi_hi", bus.hi_out, 32'hDEADBEEF);
        check("mthi_lo_kept", bus.lo_out, 32'hFFFFFFFF);
        check("mthi_no_done", 32'(bus.done), 32'd0);

        @(negedge clock);
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        sbq.push_back('{32'h0, 32'd15, 1'b0, "mult_busy_ign"});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        bus.a     = 32'h11111111;
        bus.b     = 32'h0;
        bus.op    = 2'b11;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.start = 1'b0;
        wait_done("mult_busy_ign", 32);
        repeat (5) @(posedge clock);
        #1;
        check("busy_ign_hi", bus.hi_out, 32'h0);
        check("busy_ign_lo", bus.lo_out, 32'd15);

        // reset in the middle of a MULT
        @(negedge clock);
        bus.op    = 2'b00;
        bus.a     = 32'h12345678;
        bus.b     = 32'h10;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi_out, 32'h0);
        check("abort_lo", bus.lo_out, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("abort_hi_hold", bus.hi_out, 32'h0);

        run_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, "multu_after_rst");
        repeat (2) @(posedge clock);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
